// File: rtl/apb_stream_regs_pkg.sv
// Shared types and address-map helpers for the APB stream register file.
// Offsets are in APB word units, laid out CFG, IRQ_STAT, IRQ_MASK, STAT, IN, OUT.
package apb_stream_regs_pkg;

   typedef logic [31:0] word_t;
   typedef logic [63:0] blk_t;

   typedef enum logic {
      CH_IN  = 1'b0,
      CH_OUT = 1'b1
   } chan_mode_t;

   function automatic int off_irq_stat(int n_cfg);
      return n_cfg;
   endfunction

   function automatic int off_irq_mask(int n_cfg);
      return n_cfg + 1;
   endfunction

   function automatic int off_stat(int n_cfg);
      return n_cfg + 2;
   endfunction

   function automatic int off_in(int n_cfg, int n_stat);
      return n_cfg + 2 + n_stat;
   endfunction

   function automatic int off_out(int n_cfg, int n_stat, int n_in, int wpb);
      return off_in(n_cfg, n_stat) + n_in * wpb;
   endfunction

   function automatic int off_end(int n_cfg, int n_stat, int n_in, int n_out, int wpb);
      return off_out(n_cfg, n_stat, n_in, wpb) + n_out * wpb;
   endfunction

   function automatic int irq_err_bit(int n_in, int n_out);
      return n_in + n_out;
   endfunction

endpackage

// File: rtl/apb_stream_chan.sv
// One stream channel: IN assembles words into a block and pushes it,
// OUT slices a show-ahead FIFO head and pops it after the last word is read.
module apb_stream_chan
   import apb_stream_regs_pkg::*;
#(
   parameter chan_mode_t MODE  = CH_IN,
   parameter int         DW    = 32,
   parameter int         BLK_W = 64,
   parameter int         WW    = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             acc,
   input  logic             wr,
   input  logic [WW-1:0]    w,
   input  logic [DW-1:0]    wdata,
   input  logic             flag,
   input  logic [BLK_W-1:0] blk_in,
   output logic [DW-1:0]    rdata,
   output logic             stall,
   output logic             err,
   output logic             strobe,
   output logic [BLK_W-1:0] blk
);

   localparam int WPB = BLK_W / DW;
   localparam logic [WW-1:0] LAST = WW'(WPB - 1);

   logic last;
   logic [WPB-1:0] wsel;

   assign last = (w == LAST);

   always_comb begin
      wsel = '0;
      for (int k = 0; k < WPB; k++)
         if (w == WW'(k)) wsel[k] = 1'b1;
   end

   if (MODE == CH_IN) begin : g_in
      localparam logic [WPB-1:0] LBIT = WPB'(1) << (WPB - 1);

      logic [BLK_W-1:0] buf_q;
      logic [WPB-1:0]   wmask_q;
      logic             push_q;
      logic             complete;
      logic             unused_in;

      assign unused_in = ^blk_in;
      assign complete  = &(wmask_q | LBIT);
      // An incomplete block errors immediately rather than waiting on full.
      assign stall  = acc & wr & last & complete & flag;
      assign err    = acc & wr & last & ~complete;
      assign strobe = push_q;
      assign blk    = buf_q;

      always_comb begin
         rdata = '0;
         for (int k = 0; k < WPB; k++)
            if (wsel[k]) rdata = buf_q[(WPB-1-k)*DW +: DW];
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            buf_q   <= '0;
            wmask_q <= '0;
            push_q  <= 1'b0;
         end else begin
            push_q <= 1'b0;
            if (acc & wr & ~stall) begin
               if (err) begin
                  wmask_q <= '0;
               end else begin
                  for (int k = 0; k < WPB; k++)
                     if (wsel[k]) buf_q[(WPB-1-k)*DW +: DW] <= wdata;
                  if (last) begin
                     wmask_q <= '0;
                     push_q  <= 1'b1;
                  end else begin
                     wmask_q <= wmask_q | wsel;
                  end
               end
            end
         end
      end
   end else begin : g_out
      logic pop_q;
      logic unused_out;

      assign unused_out = ^wdata;
      assign stall  = acc & ~wr & last & flag;
      assign err    = 1'b0;
      assign strobe = pop_q;
      assign blk    = '0;

      always_comb begin
         rdata = '0;
         for (int k = 0; k < WPB; k++)
            if (wsel[k] && !flag) rdata = blk_in[(WPB-1-k)*DW +: DW];
      end

      always_ff @(posedge clk) begin
         if (rst) pop_q <= 1'b0;
         else     pop_q <= acc & ~wr & last & ~flag;
      end
   end

endmodule

// File: rtl/apb_stream_regs.sv
// APB4 register file with config/status words, stream channels,
// wait-state timeout and a maskable sticky interrupt.
module apb_stream_regs
   import apb_stream_regs_pkg::*;
#(
   parameter int APB_AW  = 10,
   parameter int APB_DW  = 32,
   parameter int BLK_W   = 64,
   parameter int N_CFG   = 9,
   parameter int N_STAT  = 5,
   parameter int N_IN    = 2,
   parameter int N_OUT   = 1,
   parameter int TIMEOUT = 1024
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [APB_AW-1:0]       PADDR,
   input  logic                    PSEL,
   input  logic                    PENABLE,
   input  logic                    PWRITE,
   input  logic [APB_DW-1:0]       PWDATA,
   input  logic [APB_DW/8-1:0]     PSTRB,
   output logic [APB_DW-1:0]       PRDATA,
   output logic                    PREADY,
   output logic                    PSLVERR,
   output logic [N_CFG*APB_DW-1:0] cfg_o,
   input  logic [N_STAT*APB_DW-1:0] stat_i,
   output logic [N_IN*BLK_W-1:0]   in_data_o,
   output logic [N_IN-1:0]         in_push_o,
   input  logic [N_IN-1:0]         in_full_i,
   input  logic [N_OUT*BLK_W-1:0]  out_data_i,
   output logic [N_OUT-1:0]        out_pop_o,
   input  logic [N_OUT-1:0]        out_empty_i,
   output logic                    irq_o
);

   localparam int AB   = $clog2(APB_DW / 8);
   localparam int IW   = APB_AW - AB;
   localparam int WPB  = BLK_W / APB_DW;
   localparam int WW   = (WPB > 1) ? $clog2(WPB) : 1;
   localparam int NCH  = N_IN + N_OUT;
   localparam int NIRQ = N_IN + N_OUT + 1;
   localparam int NB   = APB_DW / 8;
   localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam bit HAS_TMO = (TIMEOUT != 0);

   localparam logic [IW-1:0] I_IRQS = IW'(off_irq_stat(N_CFG));
   localparam logic [IW-1:0] I_MASK = IW'(off_irq_mask(N_CFG));
   localparam logic [IW-1:0] I_STAT = IW'(off_stat(N_CFG));
   localparam logic [IW-1:0] I_IN   = IW'(off_in(N_CFG, N_STAT));
   localparam logic [IW-1:0] I_OUT  = IW'(off_out(N_CFG, N_STAT, N_IN, WPB));
   localparam logic [IW-1:0] I_END  = IW'(off_end(N_CFG, N_STAT, N_IN, N_OUT, WPB));

   logic [IW-1:0]     idx;
   logic              access, aligned, in_map, is_stat, is_out;
   logic              dec_err, acc_ok, wr_reg;
   logic              stall_any, chan_err, tmo;
   logic [APB_DW-1:0] bm, rd;
   logic [NCH-1:0]    ch_hit, ch_stall, ch_err;
   logic [APB_DW-1:0] ch_rd [NCH];
   logic [APB_DW-1:0] cfg_q [N_CFG];
   logic [NIRQ-1:0]   irq_stat_q, irq_mask_q, irq_set, w1c;
   logic [N_IN-1:0]   in_full_q;
   logic [N_OUT-1:0]  out_empty_q;
   logic [TW-1:0]     tcnt_q;

   assign idx     = PADDR[APB_AW-1:AB];
   assign aligned = (PADDR[AB-1:0] == '0);
   assign access  = PSEL & PENABLE;
   assign in_map  = (idx < I_END);
   assign is_stat = (idx >= I_STAT) && (idx < I_IN);
   assign is_out  = (idx >= I_OUT) && (idx < I_END);
   assign dec_err = ~aligned | ~in_map | (PWRITE & (is_stat | is_out));
   assign acc_ok  = access & ~dec_err;
   assign wr_reg  = acc_ok & PWRITE;

   for (genvar b = 0; b < NB; b++) begin : g_bm
      assign bm[b*8 +: 8] = {8{PSTRB[b]}};
   end

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      localparam logic [IW-1:0] BASE = IW'(off_in(N_CFG, N_STAT) + c * WPB);
      logic [IW-1:0] sub;

      assign sub       = idx - BASE;
      assign ch_hit[c] = (idx >= BASE) && (sub < IW'(WPB));

      if (c < N_IN) begin : g_in
         apb_stream_chan #(
            .MODE(CH_IN), .DW(APB_DW), .BLK_W(BLK_W), .WW(WW)
         ) u_chan (
            .clk(clk), .rst(rst),
            .acc(acc_ok & ch_hit[c]), .wr(PWRITE),
            .w(sub[WW-1:0]), .wdata(PWDATA),
            .flag(in_full_i[c]), .blk_in('0),
            .rdata(ch_rd[c]), .stall(ch_stall[c]), .err(ch_err[c]),
            .strobe(in_push_o[c]), .blk(in_data_o[c*BLK_W +: BLK_W])
         );
      end else begin : g_out
         logic [BLK_W-1:0] unused_blk;
         apb_stream_chan #(
            .MODE(CH_OUT), .DW(APB_DW), .BLK_W(BLK_W), .WW(WW)
         ) u_chan (
            .clk(clk), .rst(rst),
            .acc(acc_ok & ch_hit[c]), .wr(PWRITE),
            .w(sub[WW-1:0]), .wdata(PWDATA),
            .flag(out_empty_i[c-N_IN]),
            .blk_in(out_data_i[(c-N_IN)*BLK_W +: BLK_W]),
            .rdata(ch_rd[c]), .stall(ch_stall[c]), .err(ch_err[c]),
            .strobe(out_pop_o[c-N_IN]), .blk(unused_blk)
         );
      end
   end

   assign stall_any = |ch_stall;
   assign chan_err  = |ch_err;
   assign tmo       = HAS_TMO && stall_any && (tcnt_q == TW'(TIMEOUT - 1));
   assign PREADY    = access & (~stall_any | tmo);
   assign PSLVERR   = PREADY & (dec_err | chan_err | tmo);

   always_comb begin
      rd = '0;
      for (int i = 0; i < N_CFG; i++)
         if (idx == IW'(i)) rd = cfg_q[i];
      if (idx == I_IRQS) rd = APB_DW'(irq_stat_q);
      if (idx == I_MASK) rd = APB_DW'(irq_mask_q);
      for (int i = 0; i < N_STAT; i++)
         if (idx == I_STAT + IW'(i)) rd = stat_i[i*APB_DW +: APB_DW];
      for (int c = 0; c < NCH; c++)
         if (ch_hit[c]) rd = ch_rd[c];
   end

   assign PRDATA = (PSEL & ~PWRITE & ~dec_err) ? rd : '0;

   for (genvar i = 0; i < N_CFG; i++) begin : g_cfg
      assign cfg_o[i*APB_DW +: APB_DW] = cfg_q[i];
   end

   // Falling edges of full/empty mean room or data has appeared.
   assign irq_set[N_IN-1:0]     = in_full_q & ~in_full_i;
   assign irq_set[N_IN +: N_OUT] = out_empty_q & ~out_empty_i;
   assign irq_set[NIRQ-1]       = PSLVERR & (chan_err | tmo);
   assign w1c = (wr_reg && idx == I_IRQS) ? PWDATA[NIRQ-1:0] : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_CFG; i++) cfg_q[i] <= '0;
         irq_stat_q  <= '0;
         irq_mask_q  <= '0;
         in_full_q   <= '0;
         out_empty_q <= '0;
         tcnt_q      <= '0;
         irq_o       <= 1'b0;
      end else begin
         for (int i = 0; i < N_CFG; i++)
            if (wr_reg && idx == IW'(i))
               cfg_q[i] <= (cfg_q[i] & ~bm) | (PWDATA & bm);
         if (wr_reg && idx == I_MASK)
            irq_mask_q <= (irq_mask_q & ~bm[NIRQ-1:0]) |
                          (PWDATA[NIRQ-1:0] & bm[NIRQ-1:0]);
         irq_stat_q  <= (irq_stat_q & ~w1c) | irq_set;
         in_full_q   <= in_full_i;
         out_empty_q <= out_empty_i;
         irq_o       <= |(irq_stat_q & irq_mask_q);
         if (HAS_TMO && access && stall_any && !tmo)
            tcnt_q <= tcnt_q + TW'(1);
         else
            tcnt_q <= '0;
      end
   end

endmodule

// File: tb/tb_apb_stream_regs.sv
// Directed bench for apb_stream_regs: APB responses and pushes are
// queued as expectations and checked by a free-running monitor.
module tb_apb_stream_regs;
   import apb_stream_regs_pkg::*;

   typedef struct {
      logic  rd;
      word_t data;
      logic  err;
   } sb_t;

   typedef struct {
      int   s;
      blk_t d;
   } px_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [9:0]   PADDR = '0;
   logic         PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
   word_t        PWDATA = '0;
   logic [3:0]   PSTRB = '0;
   word_t        PRDATA;
   logic         PREADY, PSLVERR;
   logic [287:0] cfg_o;
   logic [159:0] stat_i = '0;
   logic [127:0] in_data_o;
   logic [1:0]   in_push_o;
   logic [1:0]   in_full_i = '0;
   logic [63:0]  out_data_i = 64'h1122334455667788;
   logic [0:0]   out_pop_o;
   logic [0:0]   out_empty_i = 1'b1;
   logic         irq_o;

   int  total = 0, bad = 0;
   sb_t sb[$];
   px_t pq[$];
   int  push_cnt[2] = '{0, 0};
   int  pop_cnt = 0;

   always #5 clk = ~clk;

   apb_stream_regs #(
      .APB_AW(10), .APB_DW(32), .BLK_W(64), .N_CFG(9), .N_STAT(5),
      .N_IN(2), .N_OUT(1), .TIMEOUT(16)
   ) dut (
      .clk(clk), .rst(rst), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA),
      .PREADY(PREADY), .PSLVERR(PSLVERR), .cfg_o(cfg_o), .stat_i(stat_i),
      .in_data_o(in_data_o), .in_push_o(in_push_o), .in_full_i(in_full_i),
      .out_data_i(out_data_i), .out_pop_o(out_pop_o),
      .out_empty_i(out_empty_i), .irq_o(irq_o)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic apb(input logic [9:0] a, input logic w, input word_t d,
                      input logic [3:0] s, input logic ee, input word_t er,
                      output int waits);
      bit done;
      waits = 0;
      done = 0;
      sb.push_back('{rd: !w, data: er, err: ee});
      @(posedge clk); #1;
      PADDR = a; PWRITE = w; PWDATA = d; PSTRB = s;
      PSEL = 1'b1; PENABLE = 1'b0;
      @(posedge clk); #1;
      PENABLE = 1'b1;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (PREADY) done = 1;
         else waits++;
      end
      if (!done) begin
         total++; bad++;
         $display("FAIL apb_timeout: addr 0x%0h got no PREADY want PREADY", a);
      end
      @(posedge clk); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   // Monitor: APB completions, stream pushes and pops.
   initial begin
      sb_t e;
      px_t p;
      forever begin
         @(negedge clk);
         if (PSEL && PENABLE && PREADY) begin
            if (sb.size() == 0) begin
               total++; bad++;
               $display("FAIL apb_unexpected: got completion want none");
            end else begin
               e = sb.pop_front();
               chk("pslverr", PSLVERR, e.err);
               if (e.rd) chk("prdata", PRDATA, e.data);
            end
         end
         for (int s = 0; s < 2; s++) begin
            if (in_push_o[s]) begin
               push_cnt[s]++;
               if (pq.size() == 0) begin
                  total++; bad++;
                  $display("FAIL push_unexpected: got push on %0d want none", s);
               end else begin
                  p = pq.pop_front();
                  chk("push_stream", s, p.s);
                  chk("push_data", in_data_o[s*64 +: 64], p.d);
               end
            end
         end
         if (out_pop_o[0]) pop_cnt++;
      end
   end

   initial begin
      int wt;
      int pc0;
      stat_i[31:0] = 32'hCAFEF00D;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pready", PREADY, 0);
      chk("rst_prdata", PRDATA, 0);
      chk("rst_irq", irq_o, 0);
      chk("rst_push", in_push_o, 0);
      chk("rst_pop", out_pop_o, 0);
      chk("rst_cfg", |cfg_o, 0);
      rst = 1'b0;

      // byte-strobed config write
      apb(10'h000, 1, 32'hA5A5A5A5, 4'b0011, 0, 0, wt);
      chk("t1_waits", wt, 0);
      chk("t1_cfg0", cfg_o[31:0], 32'h0000A5A5);

      // block assembly and push
      pq.push_back('{s: 0, d: 64'h0123456789ABCDEF});
      apb(10'h040, 1, 32'h01234567, 4'hF, 0, 0, wt);
      apb(10'h044, 1, 32'h89ABCDEF, 4'hF, 0, 0, wt);
      chk("t2_push_now", in_push_o, 2'b01);
      chk("t2_data", in_data_o[63:0], 64'h0123456789ABCDEF);
      @(posedge clk); #1;
      chk("t2_push_once", in_push_o, 2'b00);
      apb(10'h040, 0, 0, 4'h0, 0, 32'h01234567, wt);

      // backpressure on the last word
      in_full_i[0] = 1'b1;
      apb(10'h040, 1, 32'hDEADBEEF, 4'hF, 0, 0, wt);
      pq.push_back('{s: 0, d: 64'hDEADBEEF00C0FFEE});
      fork
         apb(10'h044, 1, 32'h00C0FFEE, 4'hF, 0, 0, wt);
         begin
            wait (PSEL && PENABLE);
            repeat (5) @(negedge clk);
            @(posedge clk); #1;
            in_full_i[0] = 1'b0;
         end
      join
      chk("t3_waits", wt, 5);
      repeat (2) @(posedge clk);
      #1;
      apb(10'h024, 0, 0, 4'h0, 0, 32'h1, wt);
      chk("t3_irq_masked", irq_o, 0);
      apb(10'h028, 1, 32'hF, 4'b0000, 0, 0, wt);
      apb(10'h028, 1, 32'h1, 4'b0001, 0, 0, wt);
      @(posedge clk); #1;
      chk("t3_irq_on", irq_o, 1);
      apb(10'h028, 0, 0, 4'h0, 0, 32'h1, wt);
      apb(10'h024, 1, 32'h1, 4'hF, 0, 0, wt);
      @(posedge clk); #1;
      chk("t3_irq_clr", irq_o, 0);

      // read of an empty OUT last word times out
      pc0 = pop_cnt;
      apb(10'h054, 0, 0, 4'h0, 1, 32'h0, wt);
      chk("t4_waits", wt, 15);
      repeat (2) @(posedge clk);
      #1;
      chk("t4_no_pop", pop_cnt, pc0);
      chk("t4_irq_masked", irq_o, 0);
      apb(10'h024, 0, 0, 4'h0, 0, 32'h8, wt);
      apb(10'h024, 1, 32'h8, 4'hF, 0, 0, wt);
      apb(10'h024, 0, 0, 4'h0, 0, 32'h0, wt);

      // incomplete block, then a complete one
      apb(10'h04C, 1, 32'h12345678, 4'hF, 1, 0, wt);
      apb(10'h024, 0, 0, 4'h0, 0, 32'h8, wt);
      apb(10'h024, 1, 32'h8, 4'hF, 0, 0, wt);
      pq.push_back('{s: 1, d: 64'hAAAA555512345678});
      apb(10'h048, 1, 32'hAAAA5555, 4'hF, 0, 0, wt);
      apb(10'h04C, 1, 32'h12345678, 4'hF, 0, 0, wt);
      repeat (2) @(posedge clk);
      #1;
      chk("t5_push1_count", push_cnt[1], 1);

      // decode errors leave state untouched
      apb(10'h3FC, 1, 32'hFFFFFFFF, 4'hF, 1, 0, wt);
      apb(10'h002, 1, 32'hFFFFFFFF, 4'hF, 1, 0, wt);
      apb(10'h02C, 1, 32'hFFFFFFFF, 4'hF, 1, 0, wt);
      apb(10'h3FC, 0, 0, 4'h0, 1, 32'h0, wt);
      chk("t6_cfg0", cfg_o[31:0], 32'h0000A5A5);
      apb(10'h000, 0, 0, 4'h0, 0, 32'h0000A5A5, wt);
      apb(10'h02C, 0, 0, 4'h0, 0, 32'hCAFEF00D, wt);
      apb(10'h024, 0, 0, 4'h0, 0, 32'h0, wt);

      // OUT stream with data present
      @(posedge clk); #1;
      out_empty_i[0] = 1'b0;
      repeat (2) @(posedge clk);
      pc0 = pop_cnt;
      apb(10'h050, 0, 0, 4'h0, 0, 32'h11223344, wt);
      apb(10'h054, 0, 0, 4'h0, 0, 32'h55667788, wt);
      chk("out_waits", wt, 0);
      @(posedge clk); #1;
      chk("out_pop_count", pop_cnt, pc0 + 1);
      apb(10'h024, 0, 0, 4'h0, 0, 32'h4, wt);

      repeat (3) @(posedge clk);
      chk("sb_drained", sb.size(), 0);
      chk("push_drained", pq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
